sr_latch_exerciser: RTL and testbench

- Synthesizable driver and checker for a gated SR latch. It is the drive end of the latch's En/S/R interface.
- It plays a fixed 16-step En/S/R pattern into an external latch and holds each step for HOLD_CYCLES clocks.
- At the end of each step it samples the latch's Q/Qn and compares them against an internal reference model.
- Used for on-board latch bring-up and for self-checking lab benches.

---
 rtl/sr_latch_exerciser.sv | 237 +++++++++++++++++++++++
 tb/tb_sr_latch_exerciser.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/sr_latch_exerciser.sv
// Drives a fixed 16-step En/S/R pattern into a gated SR latch and checks the synchronized Q/Qn
// against a reference model. Define SR_EXERCISER_FAILLOG_EN to add the first-failure log outputs.
module sr_latch_exerciser #(
    parameter int unsigned HOLD_CYCLES = 4,
    parameter int unsigned CNT_W       = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             Q,
    input  logic             Qn,
    output logic             En,
    output logic             S,
    output logic             R,
    output logic             busy,
    output logic             done,
    output logic             fail,
    output logic [3:0]       step_idx,
    output logic [CNT_W-1:0] err_cnt
`ifdef SR_EXERCISER_FAILLOG_EN
    ,
    output logic [3:0]       first_fail_idx,
    output logic [1:0]       first_fail_qqn,
    output logic             first_fail_vld
`endif
);

    if (HOLD_CYCLES < 3 || HOLD_CYCLES > 255) begin : gen_bad_hold
        $error("HOLD_CYCLES must be in the range 3..255");
    end

    localparam logic [7:0]       HoldLast = 8'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] ErrMax   = '1;

    typedef enum logic [1:0] {StIdle, StDrive, StSample, StDone} state_e;

    // {En, S, R} for each step of the pattern.
    function automatic logic [2:0] step_rom(input logic [3:0] idx);
        logic [2:0] v;
        v = 3'b000;
        case (idx)
            4'd0:  v = 3'b010;
            4'd1:  v = 3'b110;
            4'd2:  v = 3'b100;
            4'd3:  v = 3'b101;
            4'd4:  v = 3'b010;
            4'd5:  v = 3'b011;
            4'd6:  v = 3'b100;
            4'd7:  v = 3'b110;
            4'd8:  v = 3'b001;
            4'd9:  v = 3'b000;
            4'd10: v = 3'b111;
            4'd11: v = 3'b100;
            4'd12: v = 3'b101;
            4'd13: v = 3'b100;
            4'd14: v = 3'b110;
            default: v = 3'b000;
        endcase
        return v;
    endfunction

    state_e           state_q, state_d;
    logic [3:0]       step_q, step_d;
    logic [7:0]       hold_q, hold_d;
    logic [CNT_W-1:0] err_q, err_d;
    logic [2:0]       drv_q, drv_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             exp_q, exp_d;
    logic             exp_known_q, exp_known_d;
    logic             q_meta, q_sync, qn_meta, qn_sync;

    logic [2:0]       rom_cur;
    logic             model_exp, model_known, mismatch;

`ifdef SR_EXERCISER_FAILLOG_EN
    logic [3:0] ff_idx_q, ff_idx_d;
    logic [1:0] ff_qqn_q, ff_qqn_d;
    logic       ff_vld_q, ff_vld_d;
`endif

    // Q/Qn come straight from an asynchronous latch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_meta  <= 1'b0;
            q_sync  <= 1'b0;
            qn_meta <= 1'b0;
            qn_sync <= 1'b0;
        end else begin
            q_meta  <= Q;
            q_sync  <= q_meta;
            qn_meta <= Qn;
            qn_sync <= qn_meta;
        end
    end

    // Reference model result for the step currently being driven.
    always_comb begin
        rom_cur     = step_rom(step_q);
        model_exp   = exp_q;
        model_known = exp_known_q;
        if (rom_cur[2]) begin
            case (rom_cur[1:0])
                2'b10: begin
                    model_exp   = 1'b1;
                    model_known = 1'b1;
                end
                2'b01: begin
                    model_exp   = 1'b0;
                    model_known = 1'b1;
                end
                2'b11: model_known = 1'b0;
                default: ;
            endcase
        end
        mismatch = model_known && ((q_sync != model_exp) || (qn_sync != !model_exp));
    end

    always_comb begin
        state_d     = state_q;
        step_d      = step_q;
        hold_d      = hold_q;
        err_d       = err_q;
        drv_d       = drv_q;
        busy_d      = busy_q;
        done_d      = done_q;
        exp_d       = exp_q;
        exp_known_d = exp_known_q;
`ifdef SR_EXERCISER_FAILLOG_EN
        ff_idx_d    = ff_idx_q;
        ff_qqn_d    = ff_qqn_q;
        ff_vld_d    = ff_vld_q;
`endif
        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d     = StDrive;
                    step_d      = 4'd0;
                    hold_d      = 8'd0;
                    err_d       = '0;
                    drv_d       = step_rom(4'd0);
                    busy_d      = 1'b1;
                    done_d      = 1'b0;
                    exp_known_d = 1'b0;
`ifdef SR_EXERCISER_FAILLOG_EN
                    ff_idx_d    = 4'd0;
                    ff_qqn_d    = 2'b00;
                    ff_vld_d    = 1'b0;
`endif
                end
            end
            StDrive: begin
                hold_d = hold_q + 8'd1;
                if (hold_q == HoldLast) begin
                    state_d = StSample;
                    hold_d  = 8'd0;
                end
            end
            StSample: begin
                exp_d       = model_exp;
                exp_known_d = model_known;
                if (mismatch) begin
                    if (err_q != ErrMax) err_d = err_q + 1'b1;
`ifdef SR_EXERCISER_FAILLOG_EN
                    if (!ff_vld_q) begin
                        ff_idx_d = step_q;
                        ff_qqn_d = {q_sync, qn_sync};
                        ff_vld_d = 1'b1;
                    end
`endif
                end
                if (step_q == 4'd15) begin
                    state_d = StDone;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    state_d = StDrive;
                    step_d  = step_q + 4'd1;
                    drv_d   = step_rom(step_q + 4'd1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            step_q      <= 4'd0;
            hold_q      <= 8'd0;
            err_q       <= '0;
            drv_q       <= 3'b000;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            exp_q       <= 1'b0;
            exp_known_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            step_q      <= step_d;
            hold_q      <= hold_d;
            err_q       <= err_d;
            drv_q       <= drv_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            exp_q       <= exp_d;
            exp_known_q <= exp_known_d;
        end
    end

`ifdef SR_EXERCISER_FAILLOG_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ff_idx_q <= 4'd0;
            ff_qqn_q <= 2'b00;
            ff_vld_q <= 1'b0;
        end else begin
            ff_idx_q <= ff_idx_d;
            ff_qqn_q <= ff_qqn_d;
            ff_vld_q <= ff_vld_d;
        end
    end

    assign first_fail_idx = ff_idx_q;
    assign first_fail_qqn = ff_qqn_q;
    assign first_fail_vld = ff_vld_q;
`endif

    assign En       = drv_q[2];
    assign S        = drv_q[1];
    assign R        = drv_q[0];
    assign busy     = busy_q;
    assign done     = done_q;
    assign step_idx = step_q;
    assign err_cnt  = err_q;
    assign fail     = (err_q != '0);

endmodule

// File: tb/tb_sr_latch_exerciser.sv
// Bench for sr_latch_exerciser: a behavioural latch with selectable faults, table-driven runs,
// plus hand-written reset-abort and restart sequences. A second instance checks counter saturation.
module tb_sr_latch_exerciser;

    logic clk;
    logic rst_n;
    logic start;
    logic lat_q  = 1'b0;
    logic lat_qn = 1'b1;
    int   mode   = 0;

    logic       en, s, r, busy, done, fail;
    logic [3:0] step_idx;
    logic [4:0] err_cnt;
    logic       sat_en, sat_s, sat_r, sat_busy, sat_done, sat_fail;
    logic [3:0] sat_step;
    logic [1:0] sat_err;
`ifdef SR_EXERCISER_FAILLOG_EN
    logic [3:0] ff_idx, sat_ff_idx;
    logic [1:0] ff_qqn, sat_ff_qqn;
    logic       ff_vld, sat_ff_vld;
`endif

    sr_latch_exerciser #(.HOLD_CYCLES(4), .CNT_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .Q(lat_q), .Qn(lat_qn),
        .En(en), .S(s), .R(r), .busy(busy), .done(done), .fail(fail),
        .step_idx(step_idx), .err_cnt(err_cnt)
`ifdef SR_EXERCISER_FAILLOG_EN
        , .first_fail_idx(ff_idx), .first_fail_qqn(ff_qqn), .first_fail_vld(ff_vld)
`endif
    );

    sr_latch_exerciser #(.HOLD_CYCLES(4), .CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .start(start), .Q(lat_q), .Qn(lat_qn),
        .En(sat_en), .S(sat_s), .R(sat_r), .busy(sat_busy), .done(sat_done), .fail(sat_fail),
        .step_idx(sat_step), .err_cnt(sat_err)
`ifdef SR_EXERCISER_FAILLOG_EN
        , .first_fail_idx(sat_ff_idx), .first_fail_qqn(sat_ff_qqn), .first_fail_vld(sat_ff_vld)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Latch settles on the falling edge, well inside the allowed window.
    // 0: ideal NOR-style gated latch, 1: Q stuck 0, 2: ignores En (reset-dominant),
    // 3: ideal but S=R=1 gated forces Q=Qn=1.
    always @(negedge clk) begin
        case (mode)
            1: begin
                lat_q  <= 1'b0;
                lat_qn <= 1'b1;
            end
            2: begin
                case ({s, r})
                    2'b10:        begin lat_q <= 1'b1; lat_qn <= 1'b0; end
                    2'b01, 2'b11: begin lat_q <= 1'b0; lat_qn <= 1'b1; end
                    default: ;
                endcase
            end
            default: begin
                if (en) begin
                    case ({s, r})
                        2'b10: begin lat_q <= 1'b1; lat_qn <= 1'b0; end
                        2'b01: begin lat_q <= 1'b0; lat_qn <= 1'b1; end
                        2'b11: begin
                            lat_q  <= (mode == 3);
                            lat_qn <= (mode == 3);
                        end
                        default: ;
                    endcase
                end
            end
        endcase
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    typedef struct {
        int mode;
        int retrig;
        int exp_err;
        int exp_fidx;
        int exp_fqqn;
        int exp_fvld;
    } vec_t;

    vec_t vecs[5];

    // Start pulse, then count clocks until done; retrig > 0 pulses start again at that clock.
    task automatic run_one(input int mode_in, input int retrig, output int cycles);
        bit busy_ok;
        mode = mode_in;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("start_busy", int'(busy), 1);
        chk("start_done", int'(done), 0);
        chk("start_step", int'(step_idx), 0);
        chk("start_drv", int'({en, s, r}), 3'b010);
        chk("start_err", int'(err_cnt), 0);
`ifdef SR_EXERCISER_FAILLOG_EN
        chk("start_ffvld", int'(ff_vld), 0);
`endif
        cycles  = 0;
        busy_ok = 1'b1;
        while (cycles < 200) begin
            @(posedge clk);
            #1;
            cycles++;
            if (done) break;
            if (!busy) busy_ok = 1'b0;
            if (cycles == 4) chk("sample_step0", int'(step_idx), 0);
            if (cycles == 5) begin
                chk("step1_idx", int'(step_idx), 1);
                chk("step1_drv", int'({en, s, r}), 3'b110);
            end
            start = (cycles == retrig);
        end
        start = 1'b0;
        chk("busy_held", int'(busy_ok), 1);
        chk("run_len", cycles, 80);
    endtask

    initial begin
        int cyc;
        int sat_exp;

        vecs[0] = '{mode: 0, retrig: 0,  exp_err: 0, exp_fidx: 0, exp_fqqn: 0, exp_fvld: 0};
        vecs[1] = '{mode: 1, retrig: 0,  exp_err: 7, exp_fidx: 1, exp_fqqn: 1, exp_fvld: 1};
        vecs[2] = '{mode: 0, retrig: 10, exp_err: 0, exp_fidx: 0, exp_fqqn: 0, exp_fvld: 0};
        // Transparent latch misses steps 4, 8 and 9 (it stays 0 after step 8 clears it).
        vecs[3] = '{mode: 2, retrig: 0,  exp_err: 3, exp_fidx: 4, exp_fqqn: 2, exp_fvld: 1};
        vecs[4] = '{mode: 3, retrig: 0,  exp_err: 0, exp_fidx: 0, exp_fqqn: 0, exp_fvld: 0};

        start = 1'b0;
        rst_n = 1'b0;
        #12;
        chk("rst_drv", int'({en, s, r}), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_err", int'(err_cnt), 0);
        chk("rst_fail", int'(fail), 0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("idle_busy", int'(busy), 0);

        for (int i = 0; i < 5; i++) begin
            run_one(vecs[i].mode, vecs[i].retrig, cyc);
            sat_exp = (vecs[i].exp_err > 3) ? 3 : vecs[i].exp_err;
            chk("done", int'(done), 1);
            chk("done_busy", int'(busy), 0);
            chk("done_step", int'(step_idx), 15);
            chk("done_drv", int'({en, s, r}), 0);
            chk("err_cnt", int'(err_cnt), vecs[i].exp_err);
            chk("fail", int'(fail), int'(vecs[i].exp_err != 0));
            chk("sat_done", int'(sat_done), 1);
            chk("sat_busy", int'(sat_busy), 0);
            chk("sat_step", int'(sat_step), 15);
            chk("sat_drv", int'({sat_en, sat_s, sat_r}), 0);
            chk("sat_err", int'(sat_err), sat_exp);
            chk("sat_fail", int'(sat_fail), int'(sat_exp != 0));
`ifdef SR_EXERCISER_FAILLOG_EN
            chk("ff_vld", int'(ff_vld), vecs[i].exp_fvld);
            chk("ff_idx", int'(ff_idx), vecs[i].exp_fidx);
            chk("ff_qqn", int'(ff_qqn), vecs[i].exp_fqqn);
            chk("sat_ff_vld", int'(sat_ff_vld), vecs[i].exp_fvld);
            chk("sat_ff_idx", int'(sat_ff_idx), vecs[i].exp_fidx);
            chk("sat_ff_qqn", int'(sat_ff_qqn), vecs[i].exp_fqqn);
`endif
            repeat (3) @(posedge clk);
            #1;
            chk("done_hold", int'(done), 1);
        end

        // Reset abort in the middle of step 6 with Q stuck low.
        mode = 1;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (30) @(posedge clk);
        #2;
        chk("pre_rst_en", int'(en), 1);
        chk("pre_rst_step", int'(step_idx), 6);
        chk("pre_rst_err", int'(err_cnt), 2);
        rst_n = 1'b0;
        #1;
        chk("abort_drv", int'({en, s, r}), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_err", int'(err_cnt), 0);
        chk("abort_step", int'(step_idx), 0);
        chk("abort_fail", int'(fail), 0);
        #2;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("post_rst_done", int'(done), 0);

        run_one(0, 0, cyc);
        chk("post_rst_run_done", int'(done), 1);
        chk("post_rst_run_err", int'(err_cnt), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
